// File: rtl/pbuf_loader_pkg.sv
// pbuf_loader shared types and sizing.
// Optional bias-gradient path: PBUF_BIAS_ACC_EN.
package pbuf_loader_pkg;

  function automatic int bw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DATA_W    = 8;
  localparam int BATCH     = 32;
  localparam int DDR_W     = DATA_W * BATCH;
  localparam int RES_W     = DATA_W + bw(BATCH);
  localparam int PE_NUM    = 32;
  localparam int POOL      = 2;
  localparam int UNIT_N    = POOL * POOL;
  localparam int BUF_DEPTH = 256;
  localparam int ADDR_W    = $clog2(BUF_DEPTH);
  localparam int CNT_W     = 12;
  localparam int ACC_LAT   = 6;
  localparam int LOOP_W    = 4;
  localparam int POS_W     = ADDR_W - 4;
  localparam int PS_W      = bw(POOL);
  localparam int UNIT_IW   = 2 * PS_W;

  typedef enum logic {
    PBUF_PARAM,
    PBUF_UPDATE
  } pbuf_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PARAM,
    ST_UPDATE,
    ST_FLUSH
  } pbuf_ld_state_e;

  typedef struct packed {
    logic [CNT_W-1:0]  trans_num;
    logic [ADDR_W-1:0] base;
    logic [LOOP_W-1:0] ch_num;
    logic [LOOP_W-1:0] pix_num;
    logic [LOOP_W-1:0] row_num;
    logic              depool;
    logic [PE_NUM-1:0] mask;
  } pbuf_conf_t;

endpackage

// File: rtl/pbuf_loader_if.sv
// DDR read streams and parameter/bias buffer write ports.
interface pbuf_loader_if;
  import pbuf_loader_pkg::*;

  logic [DDR_W-1:0]        ddr1_data;
  logic                    ddr1_valid;
  logic                    ddr1_ready;
  logic [DDR_W-1:0]        ddr2_data;
  logic                    ddr2_valid;
  logic                    ddr2_ready;
  logic [UNIT_N*DDR_W-1:0] pbuf_wr_data;
  logic [ADDR_W-1:0]       pbuf_wr_addr;
  logic [PE_NUM-1:0]       pbuf_wr_en;
  logic                    bbuf_acc_en;
  logic                    bbuf_acc_new;
  logic [ADDR_W-1:0]       bbuf_acc_addr;
  logic [RES_W-1:0]        bbuf_acc_data;

  modport master (
    input  ddr1_data, ddr1_valid,
    input  ddr2_data, ddr2_valid,
    output ddr1_ready, ddr2_ready,
    output pbuf_wr_data, pbuf_wr_addr, pbuf_wr_en,
    output bbuf_acc_en, bbuf_acc_new,
    output bbuf_acc_addr, bbuf_acc_data
  );

  modport slave (
    output ddr1_data, ddr1_valid,
    output ddr2_data, ddr2_valid,
    input  ddr1_ready, ddr2_ready,
    input  pbuf_wr_data, pbuf_wr_addr, pbuf_wr_en,
    input  bbuf_acc_en, bbuf_acc_new,
    input  bbuf_acc_addr, bbuf_acc_data
  );

endinterface

// File: rtl/pbuf_loader.sv
// DDR-to-parameter-buffer loader (param / update modes).
// `define PBUF_BIAS_ACC_EN adds the bias-gradient sum path.
module pbuf_loader
  import pbuf_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  input  logic              conf_mode,
  input  logic [CNT_W-1:0]  conf_trans_num,
  input  logic [ADDR_W-1:0] conf_base_addr,
  input  logic [LOOP_W-1:0] conf_ch_num,
  input  logic [LOOP_W-1:0] conf_pix_num,
  input  logic [LOOP_W-1:0] conf_row_num,
  input  logic              conf_depool,
  input  logic [PE_NUM-1:0] conf_mask,
  pbuf_loader_if.master     bus
);

`ifdef PBUF_BIAS_ACC_EN
  localparam int FLUSH_N = (ACC_LAT > 1) ? ACC_LAT - 1 : 1;
`else
  localparam int FLUSH_N = 1;
`endif

  pbuf_ld_state_e          state_q;
  pbuf_conf_t              cfg_q;
  pbuf_conf_t              conf_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [LOOP_W-1:0]       ch_q;
  logic [LOOP_W-1:0]       pix_q;
  logic [LOOP_W-1:0]       row_q;
  logic [UNIT_N*DDR_W-1:0] wr_data_q;
  logic [ADDR_W-1:0]       wr_addr_q;
  logic [PE_NUM-1:0]       wr_en_q;

  logic                    hs;
  logic [LOOP_W-1:0]       step;
  logic [LOOP_W:0]         pix_ext;
  logic [LOOP_W:0]         row_ext;
  logic [LOOP_W:0]         pw;
  logic                    pix_wrap;
  logic                    row_wrap;
  logic                    ch_wrap;
  logic [UNIT_IW-1:0]      unit;
  logic [ADDR_W-1:0]       upd_off;
  logic [UNIT_N*DDR_W-1:0] upd_data;
  logic [PE_NUM-1:0]       upd_en;

  assign conf_d = '{
    trans_num: conf_trans_num,
    base:      conf_base_addr,
    ch_num:    conf_ch_num,
    pix_num:   conf_pix_num,
    row_num:   conf_row_num,
    depool:    conf_depool,
    mask:      conf_mask
  };

  // update mode: each stream is ready only when the other has data
  assign bus.ddr2_ready = (state_q == ST_PARAM) ||
                          (state_q == ST_UPDATE && bus.ddr1_valid);
  assign bus.ddr1_ready = (state_q == ST_UPDATE) && bus.ddr2_valid;

  assign hs = (state_q == ST_PARAM  && bus.ddr2_valid) ||
              (state_q == ST_UPDATE && bus.ddr1_valid && bus.ddr2_valid);

  assign done         = (state_q == ST_IDLE);
  assign bus.pbuf_wr_data = wr_data_q;
  assign bus.pbuf_wr_addr = wr_addr_q;
  assign bus.pbuf_wr_en   = wr_en_q;

  always_comb begin
    step     = cfg_q.depool ? LOOP_W'(POOL) : LOOP_W'(1);
    pix_ext  = {1'b0, cfg_q.pix_num};
    row_ext  = {1'b0, cfg_q.row_num};
    pix_wrap = ({1'b0, pix_q} + {1'b0, step}) > pix_ext;
    row_wrap = ({1'b0, row_q} + {1'b0, step}) > row_ext;
    ch_wrap  = (ch_q == cfg_q.ch_num);
    pw       = (pix_ext + {{LOOP_W{1'b0}}, 1'b1}) >> PS_W;
    unit     = {row_q[PS_W-1:0], pix_q[PS_W-1:0]};
    upd_off  = (ADDR_W'(ch_q) << POS_W)
             + ADDR_W'(row_q >> PS_W) * ADDR_W'(pw)
             + ADDR_W'(pix_q >> PS_W);
  end

  always_comb begin
    upd_data = {UNIT_N{bus.ddr1_data}};
    if (cfg_q.depool) begin
      for (int u = 0; u < UNIT_N; u++) begin
        for (int b = 0; b < BATCH; b++) begin
          upd_data[u*DDR_W + b*DATA_W +: DATA_W] =
            bus.ddr2_data[u*BATCH + b] ?
            bus.ddr1_data[b*DATA_W +: DATA_W] : '0;
        end
      end
    end
    for (int p = 0; p < PE_NUM; p++) begin
      upd_en[p] = cfg_q.mask[p] &&
                  (cfg_q.depool || unit == UNIT_IW'(p % UNIT_N));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      cnt_q     <= '0;
      ch_q      <= '0;
      pix_q     <= '0;
      row_q     <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= '0;
    end else begin
      wr_en_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            cfg_q   <= conf_d;
            cnt_q   <= '0;
            ch_q    <= '0;
            pix_q   <= '0;
            row_q   <= '0;
            state_q <= (pbuf_mode_e'(conf_mode) == PBUF_UPDATE) ?
                       ST_UPDATE : ST_PARAM;
          end
        end
        ST_PARAM: begin
          if (hs) begin
            wr_data_q <= {UNIT_N{bus.ddr2_data}};
            wr_addr_q <= cfg_q.base + cnt_q[ADDR_W-1:0];
            wr_en_q   <= cfg_q.mask;
            cnt_q     <= cnt_q + CNT_W'(1);
            if (cnt_q == cfg_q.trans_num) begin
              state_q <= ST_FLUSH;
              cnt_q   <= CNT_W'(FLUSH_N - 1);
            end
          end
        end
        ST_UPDATE: begin
          if (hs) begin
            wr_data_q <= upd_data;
            wr_addr_q <= cfg_q.base + upd_off;
            wr_en_q   <= upd_en;
            if (!ch_wrap) begin
              ch_q <= ch_q + LOOP_W'(1);
            end else begin
              ch_q <= '0;
              if (!pix_wrap) begin
                pix_q <= pix_q + step;
              end else begin
                pix_q <= '0;
                row_q <= row_q + step;
              end
            end
            if (ch_wrap && pix_wrap && row_wrap) begin
              state_q <= ST_FLUSH;
              cnt_q   <= CNT_W'(FLUSH_N - 1);
            end
          end
        end
        ST_FLUSH: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PBUF_BIAS_ACC_EN
  logic signed [RES_W-1:0] sum_d;
  logic                    acc_hs;
  logic [ACC_LAT-1:0]      acc_en_q;
  logic [ACC_LAT-1:0]      acc_new_q;
  logic [ADDR_W-1:0]       acc_addr_q [ACC_LAT];
  logic [RES_W-1:0]        acc_data_q [ACC_LAT];

  assign acc_hs = hs && (state_q == ST_UPDATE);

  always_comb begin
    sum_d = '0;
    for (int b = 0; b < BATCH; b++) begin
      sum_d = sum_d +
        RES_W'($signed(bus.ddr1_data[b*DATA_W +: DATA_W]));
    end
  end

  // fixed-latency delay line aligning the sum with its channel tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_en_q  <= '0;
      acc_new_q <= '0;
      for (int i = 0; i < ACC_LAT; i++) begin
        acc_addr_q[i] <= '0;
        acc_data_q[i] <= '0;
      end
    end else begin
      acc_en_q  <= {acc_en_q[ACC_LAT-2:0], acc_hs};
      acc_new_q <= {acc_new_q[ACC_LAT-2:0],
                    pix_q == '0 && row_q == '0};
      acc_addr_q[0] <= ADDR_W'(ch_q);
      acc_data_q[0] <= sum_d;
      for (int i = 1; i < ACC_LAT; i++) begin
        acc_addr_q[i] <= acc_addr_q[i-1];
        acc_data_q[i] <= acc_data_q[i-1];
      end
    end
  end

  assign bus.bbuf_acc_en   = acc_en_q[ACC_LAT-1];
  assign bus.bbuf_acc_new  = acc_new_q[ACC_LAT-1];
  assign bus.bbuf_acc_addr = acc_addr_q[ACC_LAT-1];
  assign bus.bbuf_acc_data = acc_data_q[ACC_LAT-1];
`else
  assign bus.bbuf_acc_en   = 1'b0;
  assign bus.bbuf_acc_new  = 1'b0;
  assign bus.bbuf_acc_addr = '0;
  assign bus.bbuf_acc_data = '0;
`endif

endmodule

// File: tb/tb_pbuf_loader.sv
// Self-checking bench for pbuf_loader (default build).
// Random valids/data against a loop-nest reference model.
module tb_pbuf_loader;
  import pbuf_loader_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0]       addr;
    logic [PE_NUM-1:0]       en;
    logic [UNIT_N*DDR_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              done;
  logic              conf_mode;
  logic [CNT_W-1:0]  conf_trans_num;
  logic [ADDR_W-1:0] conf_base_addr;
  logic [LOOP_W-1:0] conf_ch_num;
  logic [LOOP_W-1:0] conf_pix_num;
  logic [LOOP_W-1:0] conf_row_num;
  logic              conf_depool;
  logic [PE_NUM-1:0] conf_mask;

  pbuf_loader_if bus ();

  pbuf_loader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .done           (done),
    .conf_mode      (conf_mode),
    .conf_trans_num (conf_trans_num),
    .conf_base_addr (conf_base_addr),
    .conf_ch_num    (conf_ch_num),
    .conf_pix_num   (conf_pix_num),
    .conf_row_num   (conf_row_num),
    .conf_depool    (conf_depool),
    .conf_mask      (conf_mask),
    .bus            (bus.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DDR_W-1:0] src1 [$];
  logic [DDR_W-1:0] src2 [$];
  wr_t              exp_q [$];
  wr_t              obs_q [$];
  bit               rdy2_q [$];
  int               hs1, hs2, last_wr, done_c;

  function automatic logic [DDR_W-1:0] rnd_beat();
    logic [DDR_W-1:0] v;
    for (int j = 0; j < DDR_W/32; j++) v[j*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic void fill_src(input int n);
    src1.delete();
    src2.delete();
    for (int i = 0; i < n; i++) begin
      src1.push_back(rnd_beat());
      src2.push_back(rnd_beat());
    end
  endfunction

  // beat k lands at base+k in every unit of every masked PE
  function automatic void model_param(input int n, input int base,
                                      input logic [PE_NUM-1:0] mask);
    wr_t w;
    exp_q.delete();
    for (int k = 0; k <= n; k++) begin
      w.addr = ADDR_W'((base + k) % BUF_DEPTH);
      w.en   = mask;
      w.data = {UNIT_N{src2[k]}};
      exp_q.push_back(w);
    end
  endfunction

  function automatic void model_update(input int chn, input int pixn,
                                       input int rown, input int base,
                                       input bit dp,
                                       input logic [PE_NUM-1:0] mask);
    wr_t w;
    int  i = 0;
    int  st = dp ? POOL : 1;
    int  u;
    exp_q.delete();
    for (int r = 0; r <= rown; r += st)
      for (int x = 0; x <= pixn; x += st)
        for (int ch = 0; ch <= chn; ch++) begin
          w.addr = ADDR_W'((base + ch * 16 + (r / POOL) * ((pixn + 1) / POOL)
                            + x / POOL) % BUF_DEPTH);
          u = (r % POOL) * POOL + (x % POOL);
          for (int p = 0; p < PE_NUM; p++)
            w.en[p] = mask[p] && (dp || (p % UNIT_N) == u);
          for (int un = 0; un < UNIT_N; un++)
            for (int b = 0; b < BATCH; b++)
              w.data[un*DDR_W + b*DATA_W +: DATA_W] =
                (!dp || src2[i][un*BATCH + b]) ?
                src1[i][b*DATA_W +: DATA_W] : 8'h00;
          exp_q.push_back(w);
          i++;
        end
  endfunction

  task automatic do_start(input bit mode, input int tn, input int base,
                          input int ch, input int pix, input int row,
                          input bit dp, input logic [PE_NUM-1:0] mask);
    @(negedge clk);
    conf_mode      = mode;
    conf_trans_num = CNT_W'(tn);
    conf_base_addr = ADDR_W'(base);
    conf_ch_num    = LOOP_W'(ch);
    conf_pix_num   = LOOP_W'(pix);
    conf_row_num   = LOOP_W'(row);
    conf_depool    = dp;
    conf_mask      = mask;
    start          = 1'b1;
  endtask

  task automatic run_job(input int p1, input int p2, input bit tog,
                         input int sc);
    bit fin = 0;
    obs_q.delete();
    rdy2_q.delete();
    hs1 = 0; hs2 = 0; last_wr = -1; done_c = -1;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      start = (c == sc);
      if (c == 0) begin
        conf_base_addr = ADDR_W'($urandom());
        conf_mask      = $urandom();
        conf_trans_num = CNT_W'($urandom());
        conf_depool    = 1'($urandom());
        conf_ch_num    = LOOP_W'($urandom());
      end
      if (bus.pbuf_wr_en != '0) begin
        obs_q.push_back('{bus.pbuf_wr_addr, bus.pbuf_wr_en,
                          bus.pbuf_wr_data});
        last_wr = c;
      end
      rdy2_q.push_back(bus.ddr2_ready);
      if (done) begin
        done_c = c;
        fin = 1;
      end else begin
        bus.ddr1_valid = tog ? (c[0] == 1'b0) : ($urandom_range(99) < p1);
        bus.ddr2_valid = tog ? (c[0] == 1'b0) : ($urandom_range(99) < p2);
        bus.ddr1_data  = (hs1 < src1.size()) ? src1[hs1] : rnd_beat();
        bus.ddr2_data  = (hs2 < src2.size()) ? src2[hs2] : rnd_beat();
        #1;
        if (bus.ddr1_valid && bus.ddr1_ready) hs1++;
        if (bus.ddr2_valid && bus.ddr2_ready) hs2++;
      end
    end
    bus.ddr1_valid = 1'b0;
    bus.ddr2_valid = 1'b0;
    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL job_timeout done never rose");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.ddr1_valid = 1'b1;
    bus.ddr2_valid = 1'b1;
    bus.ddr1_data = '0;
    bus.ddr2_data = '0;
    {conf_mode, conf_trans_num, conf_base_addr, conf_ch_num} = '0;
    {conf_pix_num, conf_row_num, conf_depool, conf_mask} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL rst_done got %b exp 1", done);
    end
    n_tests++;
    if ({bus.ddr1_ready, bus.ddr2_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_ready got %b%b exp 00",
               bus.ddr1_ready, bus.ddr2_ready);
    end
    n_tests++;
    if (bus.pbuf_wr_en !== '0 || bus.bbuf_acc_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_en got %h/%b exp 0/0",
               bus.pbuf_wr_en, bus.bbuf_acc_en);
    end
    bus.ddr1_valid = 1'b0;
    bus.ddr2_valid = 1'b0;
  endtask

  task automatic test_param_basic();
    fill_src(4);
    model_param(3, 250, 32'h0000000F);
    do_start(1'b0, 3, 250, 0, 0, 0, 1'b0, 32'h0000000F);
    run_job(100, 100, 1'b0, -1);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL pb_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL pb_wr[%0d] addr %0d en %h got, exp addr %0d en %h",
                 i, obs_q[i].addr, obs_q[i].en, exp_q[i].addr, exp_q[i].en);
      end
    end
    n_tests++;
    if (hs2 != 4 || hs1 != 0) begin
      n_fail++; $display("FAIL pb_hs got %0d/%0d exp 4/0", hs2, hs1);
    end
    n_tests++;
    if (rdy2_q.size() < 5 || rdy2_q[3] !== 1'b1 || rdy2_q[4] !== 1'b0) begin
      n_fail++; $display("FAIL pb_ready_fall not low on 5th cycle");
    end
    n_tests++;
    if (done_c != last_wr + 1) begin
      n_fail++;
      $display("FAIL pb_done got cyc %0d exp %0d", done_c, last_wr + 1);
    end
  endtask

  task automatic test_param_valid();
    int n, base;
    logic [PE_NUM-1:0] mask;
    for (int it = 0; it < 4; it++) begin
      n    = (it == 0) ? 7 : $urandom_range(20);
      base = (it == 0) ? $urandom_range(255) : $urandom_range(240, 255);
      mask = $urandom() | 32'h1;
      fill_src(n + 1);
      model_param(n, base, mask);
      do_start(1'b0, n, base, 0, 0, 0, 1'b0, mask);
      run_job(50, 50, it == 0, -1);
      n_tests++;
      if (obs_q.size() != exp_q.size() || hs2 != n + 1) begin
        n_fail++;
        $display("FAIL pv_count it%0d got %0d wr %0d hs exp %0d",
                 it, obs_q.size(), hs2, n + 1);
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        n_tests++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL pv_wr it%0d[%0d] addr %0d got exp %0d",
                   it, i, obs_q[i].addr, exp_q[i].addr);
        end
      end
      n_tests++;
      if (done_c != last_wr + 1) begin
        n_fail++;
        $display("FAIL pv_done got cyc %0d exp %0d", done_c, last_wr + 1);
      end
    end
  endtask

  task automatic test_update();
    int ch, pix, row, base, nb;
    logic [PE_NUM-1:0] mask;
    for (int it = 0; it < 4; it++) begin
      ch   = (it == 0) ? 1 : $urandom_range(3);
      pix  = (it == 0) ? 3 : $urandom_range(4);
      row  = (it == 0) ? 1 : $urandom_range(3);
      base = (it == 0) ? 0 : $urandom_range(255);
      mask = (it == 0) ? '1 : ($urandom() | 32'hF);
      nb   = (ch + 1) * (pix + 1) * (row + 1);
      fill_src(nb);
      model_update(ch, pix, row, base, 1'b0, mask);
      do_start(1'b1, 0, base, ch, pix, row, 1'b0, mask);
      run_job(60, 60, 1'b0, -1);
      n_tests++;
      if (obs_q.size() != nb || hs1 != nb || hs2 != nb) begin
        n_fail++;
        $display("FAIL up_count it%0d got %0d wr %0d/%0d hs exp %0d",
                 it, obs_q.size(), hs1, hs2, nb);
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        n_tests++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL up_wr it%0d[%0d] addr %0d en %h got, exp %0d %h",
                   it, i, obs_q[i].addr, obs_q[i].en,
                   exp_q[i].addr, exp_q[i].en);
        end
      end
      n_tests++;
      if (done_c != last_wr + 1) begin
        n_fail++;
        $display("FAIL up_done got cyc %0d exp %0d", done_c, last_wr + 1);
      end
    end
  endtask

  task automatic test_depool();
    int ch, base;
    logic [PE_NUM-1:0] mask;
    logic [DDR_W-1:0]  b;
    for (int it = 0; it < 3; it++) begin
      ch   = $urandom_range(2);
      base = $urandom_range(255);
      mask = (it == 0) ? '1 : ($urandom() | 32'h1);
      fill_src(ch + 1);
      if (it == 0) begin
        b = '0;
        b[0] = 1'b1;
        b[2] = 1'b1;
        src2[0] = b;
      end
      model_update(ch, 0, 0, base, 1'b1, mask);
      do_start(1'b1, 0, base, ch, 0, 0, 1'b1, mask);
      run_job(70, 40, 1'b0, -1);
      n_tests++;
      if (obs_q.size() != ch + 1 || hs1 != ch + 1) begin
        n_fail++;
        $display("FAIL dp_count it%0d got %0d exp %0d",
                 it, obs_q.size(), ch + 1);
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        n_tests++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL dp_wr it%0d[%0d] en %h data %h got, exp %h %h",
                   it, i, obs_q[i].en, obs_q[i].data[63:0],
                   exp_q[i].en, exp_q[i].data[63:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [PE_NUM-1:0] mask;
    fill_src(21);
    do_start(1'b0, 20, 7, 0, 0, 0, 1'b0, '1);
    hs2 = 0;
    for (int c = 0; c < 50 && hs2 < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      bus.ddr2_valid = 1'b1;
      bus.ddr2_data  = src2[hs2];
      #1;
      if (bus.ddr2_valid && bus.ddr2_ready) hs2++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (hs2 != 5 || done !== 1'b1 || bus.ddr2_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_state hs %0d done %b rdy %b exp 5 1 0",
               hs2, done, bus.ddr2_ready);
    end
    n_tests++;
    if (bus.pbuf_wr_en !== '0) begin
      n_fail++; $display("FAIL rm_en got %h exp 0", bus.pbuf_wr_en);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.ddr2_valid = 1'b0;
    mask = $urandom() | 32'h1;
    fill_src(4);
    model_param(3, 100, mask);
    do_start(1'b0, 3, 100, 0, 0, 0, 1'b0, mask);
    run_job(70, 70, 1'b0, -1);
    n_tests++;
    if (obs_q.size() != 4 || hs2 != 4) begin
      n_fail++;
      $display("FAIL rm_restart got %0d wr %0d hs exp 4", obs_q.size(), hs2);
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rm_wr[%0d] addr %0d got exp %0d",
                 i, obs_q[i].addr, exp_q[i].addr);
      end
    end
  endtask

  task automatic test_back_to_back();
    int extra = 0;
    fill_src(3);
    model_param(2, 30, '1);
    do_start(1'b0, 2, 30, 0, 0, 0, 1'b0, '1);
    run_job(100, 100, 1'b0, 2);
    n_tests++;
    if (obs_q.size() != 3 || hs2 != 3) begin
      n_fail++;
      $display("FAIL bb_count got %0d wr %0d hs exp 3", obs_q.size(), hs2);
    end
    bus.ddr2_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!done || bus.ddr2_ready || bus.pbuf_wr_en != '0) extra++;
    end
    bus.ddr2_valid = 1'b0;
    n_tests++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL bb_start_ignored got %0d busy cycles exp 0", extra);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_param_basic();
    test_param_valid();
    test_update();
    test_depool();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
